// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter: buffers pushed bytes and issues one transmit pulse per
// byte, pacing each pulse on the uart's busy flag with a bounded wait for it to rise.
module uart_tx_fifo #(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned ARM_TIMEOUT = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   input  logic              tx_busy,
   output logic              transmit,
   output logic [7:0]        tx_byte,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam int unsigned CntW  = $clog2(ARM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StBusy
   } state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [7:0]          mem_q [Depth];
   logic [ADDR_W-1:0]   wptr_q, rptr_q;
   logic [ADDR_W:0]     level_q;
   logic                ovf_q;
   logic                transmit_q;
   logic [7:0]          tx_byte_q;
   logic                push, pop;

   assign full     = (level_q == (ADDR_W + 1)'(Depth));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign overflow = ovf_q;
   assign transmit = transmit_q;
   assign tx_byte  = tx_byte_q;

   // full is judged before the edge, so a push into a full FIFO is lost even if a pop coincides.
   assign push = in_valid && !full;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         StIdle: begin
            if (!empty && !tx_busy) begin
               pop     = 1'b1;
               cnt_d   = '0;
               state_d = StArm;
            end
         end
         StArm: begin
            if (tx_busy) begin
               state_d = StBusy;
            end else begin
               cnt_d = cnt_q + 1'b1;
               // uart never acknowledged: count the byte as sent rather than stall forever
               if (cnt_d == CntW'(ARM_TIMEOUT)) begin
                  state_d = StIdle;
               end
            end
         end
         StBusy: begin
            if (!tx_busy) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         transmit_q <= 1'b0;
         tx_byte_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         transmit_q <= pop;
         if (pop) begin
            tx_byte_q <= mem_q[rptr_q];
            rptr_q    <= rptr_q + 1'b1;
         end
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (in_valid && full) begin
            ovf_q <= 1'b1;
         end
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (!push && pop) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

   // Storage needs no reset; the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= in_byte;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO with a transmit sequencer, placed directly upstream of the uart transmitter.
- Absorbs byte strobes from a producer, such as the uart receiver's received/rx_byte pair or an echo/stream source.
- Issues one single-cycle transmit pulse per byte and paces each pulse on the uart's is_transmitting.
- Lets bursts of received or generated bytes be streamed back without loss, up to DEPTH bytes.

Parameters:
- ADDR_W, 4: log2 of FIFO depth; DEPTH = 2**ADDR_W = 16 bytes.
- ARM_TIMEOUT, 7: maximum cycles to wait for tx_busy to rise after a transmit pulse before treating the byte as sent.

Ports:
- clk  input  1  master clock, shared with the uart.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  single-cycle push strobe; connects to the uart received output or to a producer.
- in_byte  input  8  byte to push; sampled when in_valid=1.
- tx_busy  input  1  connects to the uart is_transmitting.
- transmit  output  1  single-cycle request to the uart; registered.
- tx_byte  output  8  byte for the uart; registered; stable from transmit assertion until the next load.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a push is dropped; cleared only by rst.

Behaviour:
- Clock and reset: a single clock, clk, with synchronous active-high reset rst. Everything is sampled on the rising edge of clk.
- Reset values: transmit=0, tx_byte=8'h00, level=0, empty=1, full=0, overflow=0. Read/write pointers=0; FSM=IDLE; timeout counter=0.
- A reset in any state aborts the sequence and discards all FIFO contents. A transmit pulse is never issued in the cycle after rst is sampled high.
- Storage: DEPTH x 8 register array.
  - Pointers are ADDR_W bits and wrap naturally modulo DEPTH.
  - level is tracked separately, at ADDR_W+1 bits.
- Push: in_valid=1 and full=0 at an edge writes in_byte at wptr; wptr+1, level+1.
- Push while full: in_valid=1 with full=1 drops the byte and sets overflow.
  - FIFO state is unchanged.
  - The byte is dropped even if a pop occurs on the same edge; full is evaluated before that edge.
- Pop: occurs only on the FSM IDLE->ARM transition; rptr+1, level-1.
- Simultaneous push and pop (not full): level is unchanged and both pointers advance.
- FSM states:
  - IDLE: if empty=0, load tx_byte <= mem[rptr], pop, assert transmit=1 for the next cycle, go to ARM.
  - ARM: transmit=0. If tx_busy=1, go to BUSY. Otherwise increment the timeout counter; on reaching ARM_TIMEOUT go to IDLE, treating the byte as consumed with no retry. The counter clears on entering ARM.
  - BUSY: wait until tx_busy=0, then go to IDLE.
- Transmit pulse: exactly one cycle wide, and at most one per byte.
  - transmit never asserts while the FSM is in ARM or BUSY.
  - transmit never asserts while tx_busy=1 as observed in IDLE; IDLE also requires tx_busy=0 before issuing.
- Latency: in_valid sampled at edge k into an empty FIFO with an idle FSM and tx_busy=0 gives transmit=1 during the cycle after edge k+1, with tx_byte valid in the same cycle.
  - Back-to-back bytes: the next transmit comes no earlier than 1 cycle after tx_busy falls.
- tx_byte holds the last sent value after the FIFO drains.

Test Plan:
- Single byte: after reset push 8'hA5 at edge 10 -> transmit high only in cycle 11-12 with tx_byte=8'hA5. Model tx_busy high for 40 cycles starting one cycle later -> no further transmit; level returns 0, empty=1.
- Burst: push 8'h01..8'h05 on consecutive cycles, tx_busy model 40 cycles per byte -> five transmit pulses in order 01..05. Each pulse occurs only after the prior tx_busy fall; overflow=0.
- Overflow: hold tx_busy=1 (FSM stuck in BUSY after the first pulse); push 18 bytes 8'h10..8'h21.
  - First byte is popped, so 16 are stored and full=1; byte 8'h21 is dropped and overflow=1.
  - Drain -> 16 bytes 8'h11..8'h20 are emitted in order.
- Timeout: tx_busy tied 0, push 8'h3C and 8'h3D -> each pulse is followed by exactly ARM_TIMEOUT ARM cycles, then the next pulse. No hang; both bytes are emitted.
- Pointer wrap: 40 push/drain cycles of 3 bytes each (120 bytes, crossing the DEPTH boundary multiple times) -> output sequence matches the input exactly; level never exceeds 3.
- Reset mid-operation: assert rst for 1 cycle while in BUSY with level=4.
  - Next cycle: level=0, empty=1, transmit=0, overflow=0.
  - A subsequent push of 8'h7E gives the normal single-byte response.
